// File: rtl/sad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sad_pkg
//  Purpose  : Shared defaults, SAD width helper and output-slot state type
//             for the SAD block accumulator.
//  Revision : 1.0  initial release
// ============================================================================
package sad_pkg;

    localparam int SAD_DW      = 9;
    localparam int SAD_BLK_LEN = 8;

    // Width that holds len summed values of dw bits without overflow
    function automatic int sad_w(input int dw, input int len);
        return dw + $clog2(len);
    endfunction

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : sad_pkg
`default_nettype wire

// File: rtl/sad_out_slot.sv
`default_nettype none
// ============================================================================
//  Module   : sad_out_slot
//  Purpose  : One-entry valid/ready holding register for a {sad,max} result.
//             A load while full is legal only when the consumer takes the
//             current entry in the same cycle (can_load reports this).
//  Revision : 1.0  initial release
// ============================================================================
module sad_out_slot
    import sad_pkg::*;
#(
    parameter int DW = SAD_DW,
    parameter int SW = sad_w(SAD_DW, SAD_BLK_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [SW-1:0] i_sad,
    input  logic [DW-1:0] i_max,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [SW-1:0] o_sad,
    output logic [DW-1:0] o_max,
    output logic          o_can_load
);

    slot_state_t r_state;
    slot_state_t w_state_nxt;
    logic [SW-1:0] r_sad;
    logic [DW-1:0] r_max;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a load always leaves the slot full, a drain without load empties it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: begin
                if (i_load) begin
                    w_state_nxt = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (i_load) begin
                    w_state_nxt = SLOT_FULL;
                end else if (i_ready) begin
                    w_state_nxt = SLOT_EMPTY;
                end
            end
            default: w_state_nxt = SLOT_EMPTY;
        endcase
    end

    // Outputs: valid while full; room exists when empty or draining this cycle
    always_comb begin
        o_valid    = (r_state == SLOT_FULL);
        o_can_load = (r_state == SLOT_EMPTY) || i_ready;
    end

    // Result payload, held stable until replaced by the next load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sad <= '0;
            r_max <= '0;
        end else if (i_load) begin
            r_sad <= i_sad;
            r_max <= i_max;
        end
    end

    assign o_sad = r_sad;
    assign o_max = r_max;

endmodule : sad_out_slot
`default_nettype wire

// File: rtl/sad_block_accum.sv
`default_nettype none
// ============================================================================
//  Module   : sad_block_accum
//  Purpose  : Sums BLK_LEN consecutive absolute differences into a SAD and
//             tracks the block maximum; results leave through a one-entry
//             valid/ready slot. Only the block-completing beat can stall.
//  Revision : 1.0  initial release
// ============================================================================
module sad_block_accum
    import sad_pkg::*;
#(
    parameter  int DW      = SAD_DW,
    parameter  int BLK_LEN = SAD_BLK_LEN,
    localparam int SW      = sad_w(DW, BLK_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_diff,
    input  logic          in_clear,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sad,
    output logic [DW-1:0] out_max
);

    localparam int            CW     = $clog2(BLK_LEN);
    localparam logic [CW-1:0] C_LAST = CW'(BLK_LEN - 1);

    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_acc;
    logic [DW-1:0] r_max;

    logic          w_last;
    logic          w_can_load;
    logic          w_accept;
    logic          w_final;
    logic [SW-1:0] w_sum;
    logic [DW-1:0] w_new_max;

    // Beat qualification; only the last beat of a block depends on slot room
    always_comb begin
        w_last    = (r_cnt == C_LAST);
        in_ready  = w_can_load || !w_last;
        w_accept  = in_valid && in_ready && !in_clear;
        w_final   = w_accept && w_last;
        w_sum     = r_acc + SW'(in_diff);
        w_new_max = (in_diff > r_max) ? in_diff : r_max;
    end

    // Block accumulator, max tracker and beat counter; clear beats a coincident beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_max <= '0;
        end else if (in_clear) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_max <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_max <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                r_acc <= w_sum;
                r_max <= w_new_max;
            end
        end
    end

    sad_out_slot #(
        .DW (DW),
        .SW (SW)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_final),
        .i_sad      (w_sum),
        .i_max      (w_new_max),
        .i_ready    (out_ready),
        .o_valid    (out_valid),
        .o_sad      (out_sad),
        .o_max      (out_max),
        .o_can_load (w_can_load)
    );

endmodule : sad_block_accum
`default_nettype wire

// File: tb/tb_sad_block_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sad_block_accum
//  Purpose  : Self-checking bench for sad_block_accum with directed steps
//             followed by random traffic against a block-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sad_block_accum;

    localparam int DW      = 9;
    localparam int BLK_LEN = 8;
    localparam int SW      = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_diff;
    logic          in_clear;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sad;
    logic [DW-1:0] out_max;

    int total = 0;
    int bad   = 0;

    // Reference model: beats of the open block, and the pending result
    int m_blk[$];
    bit m_pend;
    int m_sad;
    int m_max;

    always #5 clk = ~clk;

    sad_block_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_diff   (in_diff),
        .in_clear  (in_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sad   (out_sad),
        .out_max   (out_max)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model
    task automatic step(input bit v, input logic [DW-1:0] d, input bit clr, input bit ord);
        bit exp_rdy;
        bit fin;
        int s;
        int mx;
        in_valid  = v;
        in_diff   = d;
        in_clear  = clr;
        out_ready = ord;
        #1;
        exp_rdy = !(m_pend && !ord && (m_blk.size() == BLK_LEN - 1));
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_pend);
        if (m_pend) begin
            chk("out_sad", out_sad, m_sad);
            chk("out_max", out_max, m_max);
        end
        fin = 1'b0;
        s   = 0;
        mx  = 0;
        if (clr) begin
            m_blk.delete();
        end else if (v && exp_rdy) begin
            m_blk.push_back(int'(d));
            if (m_blk.size() == BLK_LEN) begin
                foreach (m_blk[i]) begin
                    s += m_blk[i];
                    if (m_blk[i] > mx) mx = m_blk[i];
                end
                fin = 1'b1;
                m_blk.delete();
            end
        end
        if (fin) begin
            m_pend = 1'b1;
            m_sad  = s;
            m_max  = mx;
        end else if (m_pend && ord) begin
            m_pend = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic beats(input int n, input int val, input bit ord);
        for (int i = 0; i < n; i++) step(1'b1, DW'(val), 1'b0, ord);
    endtask

    // Reset raised between edges: outputs must clear without a clock edge
    task automatic pulse_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_clear = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_sad", out_sad, 0);
        chk("rst_max", out_max, 0);
        m_blk.delete();
        m_pend = 1'b0;
        m_sad  = 0;
        m_max  = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int vals[8];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_diff   = '0;
        in_clear  = 1'b0;
        out_ready = 1'b0;
        m_pend    = 1'b0;
        m_sad     = 0;
        m_max     = 0;
        repeat (2) @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_sad", out_sad, 0);
        chk("reset_max", out_max, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: eight beats of 10, consumer always ready
        beats(8, 10, 1'b1);
        chk("t1_sad", out_sad, 80);
        chk("t1_max", out_max, 10);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t1_one_cycle", out_valid, 0);

        // 2: mixed beats with an input gap after the fourth beat
        vals = '{0, 255, 1, 2, 3, 4, 5, 6};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, DW'(vals[i]), 1'b0, 1'b1);
            if (i == 3) begin
                step(1'b0, DW'($urandom), 1'b0, 1'b1);
                step(1'b0, DW'($urandom), 1'b0, 1'b1);
            end
        end
        chk("t2_sad", out_sad, 276);
        chk("t2_max", out_max, 255);
        step(1'b0, '0, 1'b0, 1'b1);

        // 3: worst case, no wrap
        beats(8, 511, 1'b1);
        chk("t3_sad", out_sad, 4088);
        chk("t3_max", out_max, 511);
        step(1'b0, '0, 1'b0, 1'b1);

        // 4: A pending with consumer stalled, B streams in and its last beat waits
        beats(8, 20, 1'b0);
        beats(7, 30, 1'b0);
        step(1'b1, 9'd40, 1'b0, 1'b0);
        step(1'b1, 9'd40, 1'b0, 1'b0);
        chk("t4_a_held", out_sad, 160);
        step(1'b1, 9'd40, 1'b0, 1'b1);
        chk("t4_b_sad", out_sad, 250);
        chk("t4_b_max", out_max, 40);
        step(1'b0, '0, 1'b0, 1'b1);

        // 5: partial block aborted by clear, coincident beat discarded
        beats(4, 7, 1'b1);
        step(1'b1, 9'd9, 1'b1, 1'b1);
        beats(8, 1, 1'b1);
        chk("t5_sad", out_sad, 8);
        chk("t5_max", out_max, 1);
        step(1'b0, '0, 1'b0, 1'b1);

        // 6: reset with a pending result and a partial block
        beats(8, 3, 1'b0);
        beats(3, 5, 1'b0);
        pulse_reset();
        beats(8, 2, 1'b1);
        chk("t6_sad", out_sad, 16);
        chk("t6_max", out_max, 2);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            bit v;
            bit clr;
            bit ord;
            logic [DW-1:0] d;
            v   = ($urandom_range(99) < 75);
            clr = ($urandom_range(99) < 3);
            ord = ($urandom_range(99) < 50);
            d   = ($urandom_range(9) == 0) ? 9'd511 : DW'($urandom);
            if ($urandom_range(399) == 0) begin
                pulse_reset();
            end else begin
                step(v, d, clr, ord);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sad_block_accum
`default_nettype wire
